cache_ctrl_nway: RTL and testbench

// Control FSM for an NWAYS-way set-associative, write-back, write-allocate cache between the LC-3b CPU port and physical memory.

---
 rtl/cache_ctrl_nway_pkg.sv | 49 ++++
 rtl/cache_ctrl_nway_plru.sv | 28 ++
 rtl/cache_ctrl_nway.sv | 146 ++++++++++++++
 tb/tb_cache_ctrl_nway.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/cache_ctrl_nway_pkg.sv
// Shared types and tree pseudo-LRU helpers for the N-way cache controller.
// Helpers work on maximum-width vectors so any power-of-two way count up to 64 can use them.
package cache_types;

  typedef enum logic [1:0] {IDLE, CHECK, WB, FILL} state_e;

  localparam int MAX_WAYW = 6;
  localparam int MAX_BITS = (1 << MAX_WAYW) - 1;

  // Walk from the root, following each node bit toward the side it points at.
  function automatic logic [MAX_WAYW-1:0] plru_victim(input logic [MAX_BITS-1:0] bits,
                                                      input int wayw);
    int                  node;
    logic                b;
    logic [MAX_WAYW-1:0] way;
    node = 0;
    way  = '0;
    for (int lvl = 0; lvl < MAX_WAYW; lvl++) begin
      if (lvl < wayw) begin
        b    = bits[node[5:0]];
        way  = {way[MAX_WAYW-2:0], b};
        node = 2 * node + 1 + int'(b);
      end
    end
    return way;
  endfunction

  // Every node on the accessed way's path is made to point at the other subtree.
  function automatic logic [MAX_BITS-1:0] plru_update(input logic [MAX_BITS-1:0] bits,
                                                      input logic [MAX_WAYW-1:0] way,
                                                      input int wayw);
    int                  node;
    int                  sh;
    logic                b;
    logic [MAX_BITS-1:0] res;
    node = 0;
    res  = bits;
    for (int lvl = 0; lvl < MAX_WAYW; lvl++) begin
      if (lvl < wayw) begin
        sh              = wayw - 1 - lvl;
        b               = way[sh[2:0]];
        res[node[5:0]]  = ~b;
        node            = 2 * node + 1 + int'(b);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/cache_ctrl_nway_plru.sv
// Combinational tree pseudo-LRU: victim selection and access update for one set.
module cache_plru
  import cache_types::*;
#(
  parameter int NWAYS = 4,
  parameter int WAYW  = $clog2(NWAYS)
) (
  input  logic [NWAYS-2:0] plru_in,
  input  logic [WAYW-1:0]  access_way,
  output logic [WAYW-1:0]  victim,
  output logic [NWAYS-2:0] plru_out
);

  logic [MAX_BITS-1:0] bits_ext;
  logic [MAX_BITS-1:0] bits_upd;
  logic [MAX_WAYW-1:0] way_ext;
  logic [MAX_WAYW-1:0] vic_full;
  logic                unused_hi;

  assign bits_ext  = MAX_BITS'(plru_in);
  assign way_ext   = MAX_WAYW'(access_way);
  assign vic_full  = plru_victim(bits_ext, WAYW);
  assign bits_upd  = plru_update(bits_ext, way_ext, WAYW);
  assign victim    = vic_full[WAYW-1:0];
  assign plru_out  = bits_upd[NWAYS-2:0];
  assign unused_hi = ^{vic_full, bits_upd};

endmodule

// File: rtl/cache_ctrl_nway.sv
// Control FSM for an N-way set-associative write-back, write-allocate cache.
// Arrays live in the datapath; this block only raises their strobes and mux selects.
module cache_ctrl_nway
  import cache_types::*;
#(
  parameter int NWAYS = 4,
  parameter int WAYW  = $clog2(NWAYS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mem_read,
  input  logic             mem_write,
  output logic             mem_resp,
  input  logic [NWAYS-1:0] hit,
  input  logic [NWAYS-1:0] valid,
  input  logic [NWAYS-1:0] dirty,
  input  logic [NWAYS-2:0] plru_in,
  output logic [NWAYS-2:0] plru_out,
  output logic             load_lru,
  output logic [NWAYS-1:0] load_data,
  output logic [NWAYS-1:0] load_tag,
  output logic [NWAYS-1:0] load_valid,
  output logic [NWAYS-1:0] load_dirty,
  output logic             dirty_in,
  output logic             data_in_sel,
  output logic [WAYW-1:0]  way_sel,
  output logic             pmem_addr_sel,
  output logic             pmem_read,
  output logic             pmem_write,
  input  logic             pmem_resp
);

  state_e           state_q, state_d;
  logic [WAYW-1:0]  victim_q, victim_d;
  logic [WAYW-1:0]  hit_way, inv_way, plru_vic, victim;
  logic             hit_any, inv_any, req, is_write;
  logic [NWAYS-2:0] plru_upd;
  logic [NWAYS-1:0] hit_oh, vic_oh;
  logic             resp_q;

  cache_plru #(.NWAYS(NWAYS), .WAYW(WAYW)) u_plru (
    .plru_in    (plru_in),
    .access_way (hit_way),
    .victim     (plru_vic),
    .plru_out   (plru_upd)
  );

  // Descending scan so the lowest-index set bit wins.
  always_comb begin
    hit_way = '0;
    inv_way = '0;
    for (int i = NWAYS - 1; i >= 0; i--) begin
      if (hit[i])   hit_way = WAYW'(i);
      if (!valid[i]) inv_way = WAYW'(i);
    end
  end

  assign hit_any  = |hit;
  assign inv_any  = ~&valid;
  assign victim   = inv_any ? inv_way : plru_vic;
  assign req      = mem_read | mem_write;
  assign is_write = mem_write & ~mem_read;
  assign hit_oh   = NWAYS'(1) << hit_way;
  assign vic_oh   = NWAYS'(1) << victim_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      victim_q <= '0;
      resp_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
      resp_q   <= mem_resp;
    end
  end

  // NOTE: every output and next-state gets a default first, so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    victim_d      = victim_q;
    mem_resp      = 1'b0;
    plru_out      = '0;
    load_lru      = 1'b0;
    load_data     = '0;
    load_tag      = '0;
    load_valid    = '0;
    load_dirty    = '0;
    dirty_in      = 1'b0;
    data_in_sel   = 1'b0;
    way_sel       = '0;
    pmem_addr_sel = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    unique case (state_q)
      IDLE: if (req) state_d = CHECK;
      CHECK: begin
        if (!req) begin
          state_d = IDLE;
        end else if (hit_any) begin
          mem_resp = 1'b1;
          way_sel  = hit_way;
          load_lru = 1'b1;
          plru_out = plru_upd;
          state_d  = IDLE;
          if (is_write) begin
            load_data  = hit_oh;
            load_dirty = hit_oh;
            dirty_in   = 1'b1;
          end
        end else begin
          victim_d = victim;
          state_d  = dirty[victim] ? WB : FILL;
        end
      end
      WB: begin
        pmem_write    = 1'b1;
        pmem_addr_sel = 1'b1;
        way_sel       = victim_q;
        if (pmem_resp) state_d = FILL;
      end
      FILL: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          load_data   = vic_oh;
          load_tag    = vic_oh;
          load_valid  = vic_oh;
          load_dirty  = vic_oh;
          data_in_sel = 1'b1;
          state_d     = CHECK;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert ($onehot0(hit));
      assert (!(pmem_read && pmem_write));
      assert (!(mem_resp && resp_q));
    end
  end

endmodule

// File: tb/tb_cache_ctrl_nway.sv
// Directed bench for the 4-way cache controller: hits, misses, writeback, reset and withdrawal.
module tb_cache_ctrl_nway;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mem_read = 1'b0, mem_write = 1'b0, pmem_resp = 1'b0;
  logic [3:0] hit = '0, valid = '0, dirty = '0;
  logic [2:0] plru_in = '0;
  logic       mem_resp, load_lru, dirty_in, data_in_sel, pmem_addr_sel, pmem_read, pmem_write;
  logic [2:0] plru_out;
  logic [3:0] load_data, load_tag, load_valid, load_dirty;
  logic [1:0] way_sel;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int start;

  cache_ctrl_nway #(.NWAYS(4)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
    .hit(hit), .valid(valid), .dirty(dirty), .plru_in(plru_in), .plru_out(plru_out),
    .load_lru(load_lru), .load_data(load_data), .load_tag(load_tag), .load_valid(load_valid),
    .load_dirty(load_dirty), .dirty_in(dirty_in), .data_in_sel(data_in_sel), .way_sel(way_sel),
    .pmem_addr_sel(pmem_addr_sel), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_req();
    mem_read = 1'b0; mem_write = 1'b0; hit = '0; pmem_resp = 1'b0;
  endtask

  initial begin
    // Reset with a request pending: every output must stay low.
    mem_read = 1'b1; hit = 4'b0001; valid = 4'b1111;
    #12;
    check("rst_mem_resp", 32'(mem_resp), 0);
    check("rst_pmem", 32'({pmem_read, pmem_write, pmem_addr_sel}), 0);
    check("rst_loads", 32'({load_data, load_tag, load_valid, load_dirty, load_lru}), 0);
    check("rst_sel", 32'({way_sel, plru_out, dirty_in, data_in_sel}), 0);
    idle_req();
    rst_n = 1'b1;
    tick();

    // Read hit way 2, plru 000 -> root lower, node2 toward way3 = 3'b100.
    mem_read = 1'b1; hit = 4'b0100; valid = 4'b1111; plru_in = 3'b000; settle();
    check("rh_c1_resp", 32'(mem_resp), 0);
    tick();
    check("rh_c2_resp", 32'(mem_resp), 1);
    check("rh_lru", 32'(load_lru), 1);
    check("rh_plru", 32'(plru_out), 32'b100);
    check("rh_way", 32'(way_sel), 2);
    check("rh_nodata", 32'({load_data, load_dirty}), 0);
    tick(); idle_req(); settle();
    check("rh_idle_resp", 32'(mem_resp), 0);

    // Write hit way 1: merge write, mark dirty; plru 000 -> 3'b001.
    mem_write = 1'b1; hit = 4'b0010; plru_in = 3'b000;
    tick();
    check("wh_resp", 32'(mem_resp), 1);
    check("wh_load_data", 32'(load_data), 32'b0010);
    check("wh_load_dirty", 32'(load_dirty), 32'b0010);
    check("wh_dirty_in", 32'(dirty_in), 1);
    check("wh_data_sel", 32'(data_in_sel), 0);
    check("wh_plru", 32'(plru_out), 32'b001);
    tick(); idle_req();

    // Read miss, way 3 invalid, clean: fill with 5-cycle pmem latency.
    mem_read = 1'b1; valid = 4'b0111; dirty = 4'b0000;
    tick();
    check("rm_chk_resp", 32'(mem_resp), 0);
    check("rm_chk_loads", 32'({load_data, load_tag, load_valid, load_lru}), 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      check("rm_fill_read", 32'({pmem_read, pmem_write, pmem_addr_sel}), 32'b100);
      check("rm_fill_noload", 32'(load_tag), 0);
      tick();
    end
    pmem_resp = 1'b1; settle();
    check("rm_load_tag", 32'(load_tag), 32'b1000);
    check("rm_load_valid", 32'(load_valid), 32'b1000);
    check("rm_load_data", 32'(load_data), 32'b1000);
    check("rm_load_dirty", 32'(load_dirty), 32'b1000);
    check("rm_dsel_din", 32'({data_in_sel, dirty_in}), 32'b10);
    tick();
    pmem_resp = 1'b0; hit = 4'b1000; valid = 4'b1111; plru_in = 3'b011; settle();
    check("rm_resp", 32'(mem_resp), 1);
    check("rm_way", 32'(way_sel), 3);
    check("rm_pmem_off", 32'(pmem_read), 0);
    check("rm_plru_offpath", 32'(plru_out), 32'b010);
    tick(); idle_req();

    // Dirty miss: all valid, plru 000 picks way 0, which is dirty -> WB then FILL.
    mem_read = 1'b1; valid = 4'b1111; dirty = 4'b0001; plru_in = 3'b000; settle();
    start = cyc;
    tick();
    check("dm_chk_nopmem", 32'({pmem_read, pmem_write}), 0);
    tick();
    check("dm_wb", 32'({pmem_write, pmem_addr_sel, pmem_read}), 32'b110);
    check("dm_wb_way", 32'(way_sel), 0);
    tick();
    pmem_resp = 1'b1; settle();
    check("dm_wb_hold", 32'(pmem_write), 1);
    tick();
    pmem_resp = 1'b0; settle();
    check("dm_fill", 32'({pmem_read, pmem_write, pmem_addr_sel}), 32'b100);
    tick();
    pmem_resp = 1'b1; settle();
    check("dm_load_dirty", 32'(load_dirty), 32'b0001);
    check("dm_dirty_in", 32'(dirty_in), 0);
    check("dm_load_tag", 32'(load_tag), 32'b0001);
    tick();
    pmem_resp = 1'b0; hit = 4'b0001; dirty = 4'b0000; settle();
    check("dm_resp", 32'(mem_resp), 1);
    check("dm_latency", 32'(cyc - start), 6);
    check("dm_plru", 32'(plru_out), 32'b011);
    tick(); idle_req();

    // Async reset during FILL abandons the fill.
    mem_read = 1'b1; valid = 4'b0111; dirty = 4'b0000;
    tick(); tick();
    check("rf_fill", 32'(pmem_read), 1);
    #2;
    rst_n = 1'b0; pmem_resp = 1'b1; #1;
    check("rf_pmem_drop", 32'({pmem_read, pmem_write}), 0);
    check("rf_no_loads", 32'({load_data, load_tag, load_valid, load_dirty}), 0);
    check("rf_no_resp", 32'(mem_resp), 0);
    idle_req();
    tick();
    rst_n = 1'b1;
    tick();
    check("rf_idle", 32'({mem_resp, pmem_read, pmem_write}), 0);
    mem_read = 1'b1; hit = 4'b0001; valid = 4'b1111;
    tick();
    check("rf_recover_resp", 32'(mem_resp), 1);
    tick(); idle_req();

    // Request withdrawn during WB: WB and FILL complete, no mem_resp.
    mem_write = 1'b1; valid = 4'b1111; dirty = 4'b0001; plru_in = 3'b000;
    tick(); tick();
    mem_write = 1'b0; settle();
    check("wd_wb", 32'(pmem_write), 1);
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0; settle();
    check("wd_fill", 32'(pmem_read), 1);
    pmem_resp = 1'b1; settle();
    check("wd_load_valid", 32'(load_valid), 32'b0001);
    tick();
    pmem_resp = 1'b0; dirty = 4'b0000; hit = 4'b0001; settle();
    check("wd_chk_noresp", 32'({mem_resp, load_lru}), 0);
    tick(); hit = 4'b0000; settle();
    check("wd_idle", 32'({mem_resp, pmem_read, pmem_write}), 0);
    tick();

    // Read and write together behave as a read.
    mem_read = 1'b1; mem_write = 1'b1; hit = 4'b0001; plru_in = 3'b000;
    tick();
    check("rw_resp", 32'(mem_resp), 1);
    check("rw_as_read", 32'({load_data, load_dirty, dirty_in}), 0);
    tick(); idle_req();

    // All ways invalid: victim way 0.
    mem_read = 1'b1; valid = 4'b0000; dirty = 4'b0000;
    tick(); tick();
    pmem_resp = 1'b1; settle();
    check("ai_load_valid", 32'(load_valid), 32'b0001);
    tick();
    pmem_resp = 1'b0; hit = 4'b0001; valid = 4'b0001; settle();
    check("ai_resp", 32'(mem_resp), 1);
    tick(); idle_req();

    // Stray pmem_resp in IDLE is ignored.
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0; settle();
    check("ig_idle", 32'({mem_resp, pmem_read, pmem_write, load_valid}), 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
